// File: rtl/rvj1_mem_arbiter.sv
// Purpose: round-robin arbiter sharing one SRAM port between instruction fetch and data access.
// Latency: requests and responses pass through combinationally, so the arbiter adds no cycles.
// Backpressure: SRAM stalls hold the grant; requests stop while the in-flight ID FIFO is full; responses follow the owner's ready.

// Small synchronous FIFO: the head is readable combinationally, pushes when full and pops when empty are ignored.
module rvj1_mem_arbiter_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // The pointers carry one wrap bit so that full and empty can be told apart.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state computation for the storage array and both pointers.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat_i;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Storage and pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

module rvj1_mem_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    // instruction fetch port
    input  logic [DATA_WIDTH-1:0] instr_req_addr_i,
    input  logic                  instr_req_valid_i,
    output logic                  instr_req_ready_o,
    output logic [DATA_WIDTH-1:0] instr_rsp_data_o,
    output logic                  instr_rsp_error_o,
    output logic                  instr_rsp_valid_o,
    input  logic                  instr_rsp_ready_i,
    // load/store port
    input  logic [DATA_WIDTH-1:0] data_req_addr_i,
    input  logic [DATA_WIDTH-1:0] data_req_data_i,
    input  logic [3:0]            data_req_strobe_i,
    input  logic                  data_req_write_i,
    input  logic                  data_req_valid_i,
    output logic                  data_req_ready_o,
    output logic [DATA_WIDTH-1:0] data_rsp_data_o,
    output logic                  data_rsp_error_o,
    output logic                  data_rsp_valid_o,
    input  logic                  data_rsp_ready_i,
    // shared SRAM port
    output logic [DATA_WIDTH-1:0] mem_req_addr_o,
    output logic [DATA_WIDTH-1:0] mem_req_data_o,
    output logic [3:0]            mem_req_strobe_o,
    output logic                  mem_req_write_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
    input  logic                  mem_rsp_error_i,
    input  logic                  mem_rsp_valid_i,
    output logic                  mem_rsp_ready_o,
    // status
    output logic                  spurious_o
);

    // Requester IDs as stored in the in-flight FIFO.
    localparam logic ID_INSTR = 1'b0;
    localparam logic ID_DATA  = 1'b1;

    logic hold_q,     hold_d;      // grant frozen by an SRAM stall
    logic hold_gnt_q, hold_gnt_d;  // requester that owns the frozen grant
    logic last_q,     last_d;      // requester granted by the most recent handshake
    logic spurious_q, spurious_d;

    logic gnt;
    logic gnt_vld;
    logic req_rdy;
    logic mem_hs;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_head;
    logic rsp_pop;

    // Round-robin pick: a stalled grant persists, a tie goes to the requester not served last, a lone requester wins.
    always_comb begin
        gnt = ID_INSTR;
        if (hold_q) begin
            gnt = hold_gnt_q;
        end else if (instr_req_valid_i && data_req_valid_i) begin
            gnt = ~last_q;
        end else if (data_req_valid_i) begin
            gnt = ID_DATA;
        end
    end

    assign gnt_vld = (gnt == ID_DATA) ? data_req_valid_i : instr_req_valid_i;

    // A request may only leave once there is space to remember whose response is coming back.
    assign mem_req_valid_o   = rstn_i && gnt_vld && !fifo_full;
    assign req_rdy           = rstn_i && mem_req_ready_i && !fifo_full;
    assign instr_req_ready_o = req_rdy && (gnt == ID_INSTR);
    assign data_req_ready_o  = req_rdy && (gnt == ID_DATA);
    assign mem_hs            = mem_req_valid_o && mem_req_ready_i;

    // Fetches are always plain word reads, so the write-side fields are zeroed.
    always_comb begin
        mem_req_addr_o   = instr_req_addr_i;
        mem_req_data_o   = '0;
        mem_req_strobe_o = 4'b0000;
        mem_req_write_o  = 1'b0;
        if (gnt == ID_DATA) begin
            mem_req_addr_o   = data_req_addr_i;
            mem_req_data_o   = data_req_data_i;
            mem_req_strobe_o = data_req_strobe_i;
            mem_req_write_o  = data_req_write_i;
        end
    end

    // In-flight requester IDs; the head names the owner of the next SRAM response.
    rvj1_mem_arbiter_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .push_i     (mem_hs),
        .push_dat_i (gnt),
        .pop_i      (rsp_pop),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Steer the response to the head owner; with nothing outstanding it is swallowed and flagged.
    always_comb begin
        instr_rsp_valid_o = 1'b0;
        data_rsp_valid_o  = 1'b0;
        mem_rsp_ready_o   = 1'b0;
        if (rstn_i) begin
            if (fifo_empty) begin
                mem_rsp_ready_o = 1'b1;
            end else if (fifo_head == ID_DATA) begin
                data_rsp_valid_o = mem_rsp_valid_i;
                mem_rsp_ready_o  = data_rsp_ready_i;
            end else begin
                instr_rsp_valid_o = mem_rsp_valid_i;
                mem_rsp_ready_o   = instr_rsp_ready_i;
            end
        end
    end

    assign instr_rsp_data_o  = mem_rsp_data_i;
    assign instr_rsp_error_o = mem_rsp_error_i;
    assign data_rsp_data_o   = mem_rsp_data_i;
    assign data_rsp_error_o  = mem_rsp_error_i;
    assign rsp_pop           = mem_rsp_valid_i && mem_rsp_ready_o && !fifo_empty;
    assign spurious_o        = spurious_q;

    // Next-state values for the grant hold, the round-robin pointer and the sticky spurious flag.
    always_comb begin
        hold_d     = mem_req_valid_o && !mem_req_ready_i;
        hold_gnt_d = gnt;
        last_d     = mem_hs ? gnt : last_q;
        spurious_d = spurious_q || (mem_rsp_valid_i && mem_rsp_ready_o && fifo_empty);
    end

    // Arbiter state registers; after reset the fetch side counts as last served, so data wins the first tie.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hold_q     <= 1'b0;
            hold_gnt_q <= ID_INSTR;
            last_q     <= ID_INSTR;
            spurious_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_gnt_q <= hold_gnt_d;
            last_q     <= last_d;
            spurious_q <= spurious_d;
        end
    end

endmodule

// File: tb/tb_rvj1_mem_arbiter.sv
module tb_rvj1_mem_arbiter;

    localparam int DW   = 32;
    localparam int MAXO = 2;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic [DW-1:0] instr_req_addr_i = '0;
    logic          instr_req_valid_i = 1'b0;
    logic          instr_req_ready_o;
    logic [DW-1:0] instr_rsp_data_o;
    logic          instr_rsp_error_o;
    logic          instr_rsp_valid_o;
    logic          instr_rsp_ready_i = 1'b0;
    logic [DW-1:0] data_req_addr_i = '0;
    logic [DW-1:0] data_req_data_i = '0;
    logic [3:0]    data_req_strobe_i = '0;
    logic          data_req_write_i = 1'b0;
    logic          data_req_valid_i = 1'b0;
    logic          data_req_ready_o;
    logic [DW-1:0] data_rsp_data_o;
    logic          data_rsp_error_o;
    logic          data_rsp_valid_o;
    logic          data_rsp_ready_i = 1'b0;
    logic [DW-1:0] mem_req_addr_o;
    logic [DW-1:0] mem_req_data_o;
    logic [3:0]    mem_req_strobe_o;
    logic          mem_req_write_o;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i = 1'b0;
    logic [DW-1:0] mem_rsp_data_i = '0;
    logic          mem_rsp_error_i = 1'b0;
    logic          mem_rsp_valid_i = 1'b0;
    logic          mem_rsp_ready_o;
    logic          spurious_o;

    rvj1_mem_arbiter #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .instr_req_addr_i(instr_req_addr_i), .instr_req_valid_i(instr_req_valid_i),
        .instr_req_ready_o(instr_req_ready_o), .instr_rsp_data_o(instr_rsp_data_o),
        .instr_rsp_error_o(instr_rsp_error_o), .instr_rsp_valid_o(instr_rsp_valid_o),
        .instr_rsp_ready_i(instr_rsp_ready_i),
        .data_req_addr_i(data_req_addr_i), .data_req_data_i(data_req_data_i),
        .data_req_strobe_i(data_req_strobe_i), .data_req_write_i(data_req_write_i),
        .data_req_valid_i(data_req_valid_i), .data_req_ready_o(data_req_ready_o),
        .data_rsp_data_o(data_rsp_data_o), .data_rsp_error_o(data_rsp_error_o),
        .data_rsp_valid_o(data_rsp_valid_o), .data_rsp_ready_i(data_rsp_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
        .mem_req_strobe_o(mem_req_strobe_o), .mem_req_write_o(mem_req_write_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_error_i(mem_rsp_error_i),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
        .spurious_o(spurious_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // stimulus knobs, in percent per cycle
    int p_iv, p_dv, p_mr, p_rsp, p_irr, p_drr;

    // transfers the monitor saw happen at the coming edge
    bit            i_acc, d_acc, m_acc, r_acc;
    logic [DW-1:0] m_acc_addr;

    // SRAM model: addresses accepted and not yet answered, in order
    logic [DW-1:0] sram_q[$];

    // Reference model: expected responses in request order, plus round-robin state
    typedef struct {
        bit            who;   // 0 = fetch, 1 = data
        logic [DW-1:0] data;
        bit            err;
    } exp_t;
    exp_t exp_q[$];
    bit   last_g, locked, lock_g, spur_exp;

    function automatic logic [DW-1:0] rsp_data(input logic [DW-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic bit rsp_err(input logic [DW-1:0] a);
        return a[4];
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and scoreboard: compares DUT outputs against the model, away from the rising edge.
    always @(negedge clk_i) begin
        bit            g, ev;
        int            occ;
        exp_t          h;
        logic [DW-1:0] pa, pd;
        logic [3:0]    ps;
        logic          pw;
        i_acc      = instr_req_valid_i && instr_req_ready_o;
        d_acc      = data_req_valid_i && data_req_ready_o;
        m_acc      = mem_req_valid_o && mem_req_ready_i;
        m_acc_addr = mem_req_addr_o;
        r_acc      = mem_rsp_valid_i && mem_rsp_ready_o;
        if (!rstn_i) begin
            chk32("reset_outputs", {25'd0, instr_req_ready_o, data_req_ready_o, mem_req_valid_o,
                  mem_rsp_ready_o, instr_rsp_valid_o, data_rsp_valid_o, spurious_o}, 32'd0);
            exp_q.delete();
            last_g   = 1'b0;
            locked   = 1'b0;
            spur_exp = 1'b0;
        end else begin
            occ = exp_q.size();
            chk1("spurious_flag", spurious_o, spur_exp);
            // response side
            if (mem_rsp_valid_i) begin
                if (occ == 0) begin
                    chk1("spur_mem_rsp_ready", mem_rsp_ready_o, 1'b1);
                    chk1("spur_no_instr_rsp", instr_rsp_valid_o, 1'b0);
                    chk1("spur_no_data_rsp", data_rsp_valid_o, 1'b0);
                    spur_exp = 1'b1;
                end else begin
                    h = exp_q[0];
                    if (h.who) begin
                        chk1("data_rsp_valid", data_rsp_valid_o, 1'b1);
                        chk1("instr_rsp_quiet", instr_rsp_valid_o, 1'b0);
                        chk32("data_rsp_data", data_rsp_data_o, h.data);
                        chk1("data_rsp_error", data_rsp_error_o, h.err);
                        chk1("mem_rsp_ready_data", mem_rsp_ready_o, data_rsp_ready_i);
                        if (data_rsp_ready_i) void'(exp_q.pop_front());
                    end else begin
                        chk1("instr_rsp_valid", instr_rsp_valid_o, 1'b1);
                        chk1("data_rsp_quiet", data_rsp_valid_o, 1'b0);
                        chk32("instr_rsp_data", instr_rsp_data_o, h.data);
                        chk1("instr_rsp_error", instr_rsp_error_o, h.err);
                        chk1("mem_rsp_ready_instr", mem_rsp_ready_o, instr_rsp_ready_i);
                        if (instr_rsp_ready_i) void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk1("idle_instr_rsp", instr_rsp_valid_o, 1'b0);
                chk1("idle_data_rsp", data_rsp_valid_o, 1'b0);
            end
            // request side
            if (locked) g = lock_g;
            else if (instr_req_valid_i && data_req_valid_i) g = !last_g;
            else g = data_req_valid_i;
            ev = (instr_req_valid_i || data_req_valid_i) && (occ < MAXO);
            chk1("mem_req_valid", mem_req_valid_o, ev);
            if (ev) begin
                if (g) {pa, pd, ps, pw} = {data_req_addr_i, data_req_data_i, data_req_strobe_i, data_req_write_i};
                else   {pa, pd, ps, pw} = {instr_req_addr_i, 32'd0, 4'd0, 1'b0};
                chk32("mem_req_addr", mem_req_addr_o, pa);
                chk32("mem_req_data", mem_req_data_o, pd);
                chk32("mem_req_strobe_write", {27'd0, mem_req_strobe_o, mem_req_write_o}, {27'd0, ps, pw});
                chk1("instr_req_ready", instr_req_ready_o, !g && mem_req_ready_i);
                chk1("data_req_ready", data_req_ready_o, g && mem_req_ready_i);
                if (mem_req_ready_i) begin
                    exp_q.push_back('{g, rsp_data(pa), rsp_err(pa)});
                    last_g = g;
                    locked = 1'b0;
                end else begin
                    locked = 1'b1;
                    lock_g = g;
                end
            end else begin
                locked = 1'b0;
                if (instr_req_valid_i) chk1("instr_req_blocked", instr_req_ready_o, 1'b0);
                if (data_req_valid_i)  chk1("data_req_blocked", data_req_ready_o, 1'b0);
            end
        end
    end

    // One clock of stimulus: requesters, SRAM model and response consumers.
    task automatic step();
        @(posedge clk_i);
        #1;
        if (r_acc) begin
            mem_rsp_valid_i = 1'b0;
            if (sram_q.size() > 0) void'(sram_q.pop_front());
        end
        if (m_acc) sram_q.push_back(m_acc_addr);
        if (!rstn_i) begin
            instr_req_valid_i = 1'b0;
            data_req_valid_i  = 1'b0;
        end else begin
            if (i_acc) instr_req_valid_i = 1'b0;
            if (!instr_req_valid_i && pct(p_iv)) begin
                instr_req_valid_i = 1'b1;
                instr_req_addr_i  = $urandom & 32'hFFFF_FFFC;
            end
            if (d_acc) data_req_valid_i = 1'b0;
            if (!data_req_valid_i && pct(p_dv)) begin
                data_req_valid_i  = 1'b1;
                data_req_addr_i   = $urandom & 32'hFFFF_FFFC;
                data_req_data_i   = $urandom;
                data_req_strobe_i = 4'($urandom_range(15, 0));
                data_req_write_i  = 1'($urandom_range(1, 0));
            end
        end
        mem_req_ready_i   = pct(p_mr);
        instr_rsp_ready_i = pct(p_irr);
        data_rsp_ready_i  = pct(p_drr);
        if (!mem_rsp_valid_i && sram_q.size() > 0 && pct(p_rsp)) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = rsp_data(sram_q[0]);
            mem_rsp_error_i = rsp_err(sram_q[0]);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic knobs(input int iv, input int dv, input int mr, input int rs, input int irr, input int drr);
        p_iv = iv; p_dv = dv; p_mr = mr; p_rsp = rs; p_irr = irr; p_drr = drr;
    endtask

    initial begin
        int n;
        knobs(0, 0, 0, 0, 0, 0);
        run(3);
        rstn_i = 1'b1;

        // saturated traffic: data first after reset, then strict alternation
        knobs(100, 100, 100, 100, 100, 100);
        run(40);
        // random mix with SRAM stalls and slow consumers
        knobs(50, 50, 40, 50, 70, 70);
        run(1500);
        // stalled data consumer fills the ID FIFO, then drains
        knobs(80, 80, 80, 80, 100, 0);
        run(200);
        knobs(80, 80, 80, 80, 100, 100);
        run(200);

        // leave requests in flight, reset, then let their stale responses arrive
        knobs(100, 100, 100, 0, 100, 100);
        run(6);
        knobs(0, 0, 100, 0, 100, 100);
        rstn_i = 1'b0;
        run(2);
        rstn_i = 1'b1;
        knobs(0, 0, 100, 100, 100, 100);
        n = 0;
        while ((sram_q.size() > 0 || mem_rsp_valid_i) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL stale_drain_timeout: %0d responses still pending after %0d cycles", sram_q.size(), n);
        end
        run(2);
        chk1("spurious_set_after_stale", spurious_o, 1'b1);
        run(5);
        chk1("spurious_sticky", spurious_o, 1'b1);

        // clean reset clears the flag, then more random traffic
        rstn_i = 1'b0;
        sram_q.delete();
        mem_rsp_valid_i = 1'b0;
        run(2);
        rstn_i = 1'b1;
        knobs(60, 60, 50, 60, 60, 60);
        run(500);
        knobs(0, 0, 100, 100, 100, 100);
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
